// File: rtl/bit_population_counter_pkg.sv
// Shared types and elaboration helpers for the pipelined bit population counter.
package bit_population_counter_pkg;

   typedef enum logic [1:0] {
      MODE_ONES  = 2'd0,
      MODE_ZEROS = 2'd1,
      MODE_ACC   = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_t;

   // Sideband travelling alongside each beat through every pipeline stage.
   typedef struct packed {
      logic  val;
      mode_t mode;
      logic  last;
   } beat_ctrl_t;

   localparam int unsigned MAX_CHUNK  = 64;
   localparam int unsigned LEAF_CNT_W = 7;

   // Leaf chunks are zero-extended to MAX_CHUNK bits before counting.
   function automatic logic [LEAF_CNT_W-1:0] popcnt_leaf(input logic [MAX_CHUNK-1:0] bits);
      logic [LEAF_CNT_W-1:0] cnt;
      cnt = '0;
      for (int unsigned i = 0; i < MAX_CHUNK; i++) begin
         cnt = cnt + LEAF_CNT_W'(bits[i]);
      end
      return cnt;
   endfunction

   function automatic int unsigned tree_depth(input int unsigned n_leaf);
      return $clog2(n_leaf);
   endfunction

   function automatic int unsigned level_w(input int unsigned chunk, input int unsigned lvl);
      return $clog2(chunk + 1) + lvl;
   endfunction

endpackage

// File: rtl/bit_population_counter_pipe_if.sv
// Stream bundle: input beats with mode/last plus the count result channel.
interface bit_population_counter_pipe_if
   import bit_population_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned ACC_W = 32
) ();

   logic [WIDTH-1:0] data_i;
   mode_t            mode_i;
   logic             data_last_i;
   logic             data_val_i;
   logic             data_ready_o;
   logic [ACC_W-1:0] data_o;
   logic             sat_o;
   logic             data_val_o;
   logic             data_ready_i;

   modport slave (
      input  data_i, mode_i, data_last_i, data_val_i, data_ready_i,
      output data_ready_o, data_o, sat_o, data_val_o
   );

   modport master (
      output data_i, mode_i, data_last_i, data_val_i, data_ready_i,
      input  data_ready_o, data_o, sat_o, data_val_o
   );

endinterface

// File: rtl/bit_population_counter_pipe_tree_level.sv
// One registered level of the adder tree: sums adjacent pairs, growing one bit.
module popcnt_tree_level
   import bit_population_counter_pkg::*;
#(
   parameter int unsigned N_IN = 2,
   parameter int unsigned W_IN = 4
) (
   input  logic                             clk_i,
   input  logic                             srst_i,
   input  logic                             en_i,
   input  beat_ctrl_t                       ctrl_i,
   input  logic [N_IN*W_IN-1:0]             data_i,
   output beat_ctrl_t                       ctrl_o,
   output logic [(N_IN/2)*(W_IN+1)-1:0]     data_o
);

   localparam int unsigned N_OUT = N_IN / 2;
   localparam int unsigned W_OUT = W_IN + 1;

   logic [N_OUT*W_OUT-1:0] sum_d, sum_q;
   beat_ctrl_t             ctrl_q;

   always_comb begin
      sum_d = '0;
      for (int unsigned i = 0; i < N_OUT; i++) begin
         sum_d[i*W_OUT +: W_OUT] = W_OUT'(data_i[(2*i)*W_IN +: W_IN])
                                 + W_OUT'(data_i[(2*i+1)*W_IN +: W_IN]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!srst_i) begin
         ctrl_q <= '0;
         sum_q  <= '0;
      end else if (en_i) begin
         ctrl_q <= ctrl_i;
         sum_q  <= sum_d;
      end
   end

   assign ctrl_o = ctrl_q;
   assign data_o = sum_q;

endmodule

// File: rtl/bit_population_counter_pipe.sv
// Pipelined ones/zeros counter with a saturating per-packet accumulate mode
// and a single global stall driven by output backpressure.
module bit_population_counter_pipe
   import bit_population_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned CHUNK = 8,
   parameter int unsigned ACC_W = 32
) (
   input  logic                           clk_i,
   input  logic                           srst_i,
   bit_population_counter_pipe_if.slave   bus
);

   localparam int unsigned N_LEAF = WIDTH / CHUNK;
   localparam int unsigned T      = tree_depth(N_LEAF);
   localparam int unsigned LEAF_W = level_w(CHUNK, 0);
   localparam int unsigned CNT_W  = level_w(CHUNK, T);

   logic en;

   assign en               = !(bus.data_val_o && !bus.data_ready_i);
   assign bus.data_ready_o = en && srst_i;

   // Stage 0: leaf popcounts of the word (inverted for zero counting).
   logic [WIDTH-1:0]         leaf_src;
   logic [N_LEAF*LEAF_W-1:0] leaf_d, leaf_q;
   beat_ctrl_t               ctrl0_d, ctrl0_q;

   always_comb begin
      leaf_src = (bus.mode_i == MODE_ZEROS) ? ~bus.data_i : bus.data_i;
      leaf_d   = '0;
      for (int unsigned i = 0; i < N_LEAF; i++) begin
         leaf_d[i*LEAF_W +: LEAF_W] =
            LEAF_W'(popcnt_leaf(MAX_CHUNK'(leaf_src[i*CHUNK +: CHUNK])));
      end
      ctrl0_d      = '0;
      ctrl0_d.val  = bus.data_val_i;
      ctrl0_d.mode = bus.mode_i;
      ctrl0_d.last = bus.data_last_i;
   end

   always_ff @(posedge clk_i) begin
      if (!srst_i) begin
         ctrl0_q <= '0;
         leaf_q  <= '0;
      end else if (en) begin
         ctrl0_q <= ctrl0_d;
         leaf_q  <= leaf_d;
      end
   end

   logic [CNT_W-1:0] tree_cnt;
   beat_ctrl_t       tree_ctrl;

   if (T == 0) begin : g_no_tree
      assign tree_cnt  = CNT_W'(leaf_q);
      assign tree_ctrl = ctrl0_q;
   end else begin : g_tree
      for (genvar l = 0; l < T; l++) begin : g_lvl
         localparam int unsigned NI = N_LEAF >> l;
         localparam int unsigned WI = level_w(CHUNK, l);

         logic [NI*WI-1:0]          lvl_in;
         logic [(NI/2)*(WI+1)-1:0]  lvl_out;
         beat_ctrl_t                ctrl_in, ctrl_out;

         if (l == 0) begin : g_src
            assign lvl_in  = leaf_q;
            assign ctrl_in = ctrl0_q;
         end else begin : g_src
            assign lvl_in  = g_lvl[l-1].lvl_out;
            assign ctrl_in = g_lvl[l-1].ctrl_out;
         end

         popcnt_tree_level #(
            .N_IN (NI),
            .W_IN (WI)
         ) u_level (
            .clk_i  (clk_i),
            .srst_i (srst_i),
            .en_i   (en),
            .ctrl_i (ctrl_in),
            .data_i (lvl_in),
            .ctrl_o (ctrl_out),
            .data_o (lvl_out)
         );
      end
      assign tree_cnt  = g_lvl[T-1].lvl_out;
      assign tree_ctrl = g_lvl[T-1].ctrl_out;
   end

   // Output stage: the accumulator clears in the same update that emits a
   // packet result, so a following packet can start with no gap.
   logic [ACC_W-1:0] acc_d, acc_q, data_d, data_q, sum_sat;
   logic [ACC_W:0]   sum;
   logic             ovf, sticky_d, sticky_q, sat_d, sat_q, val_d, val_q;

   always_comb begin
      sum      = {1'b0, acc_q} + (ACC_W+1)'(tree_cnt);
      ovf      = sum[ACC_W];
      sum_sat  = ovf ? '1 : sum[ACC_W-1:0];
      acc_d    = acc_q;
      sticky_d = sticky_q;
      data_d   = data_q;
      sat_d    = sat_q;
      val_d    = 1'b0;
      if (tree_ctrl.val) begin
         if (tree_ctrl.mode == MODE_ACC) begin
            if (tree_ctrl.last) begin
               data_d   = sum_sat;
               sat_d    = sticky_q | ovf;
               val_d    = 1'b1;
               acc_d    = '0;
               sticky_d = 1'b0;
            end else begin
               acc_d    = sum_sat;
               sticky_d = sticky_q | ovf;
            end
         end else begin
            data_d = ACC_W'(tree_cnt);
            sat_d  = 1'b0;
            val_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!srst_i) begin
         acc_q    <= '0;
         sticky_q <= 1'b0;
         data_q   <= '0;
         sat_q    <= 1'b0;
         val_q    <= 1'b0;
      end else if (en) begin
         acc_q    <= acc_d;
         sticky_q <= sticky_d;
         data_q   <= data_d;
         sat_q    <= sat_d;
         val_q    <= val_d;
      end
   end

   assign bus.data_o     = data_q;
   assign bus.sat_o      = sat_q;
   assign bus.data_val_o = val_q;

endmodule
